// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: opcodes, data width,
// FSM states and the opcode carry-validity helper.
package alu_pkg;

    localparam int DW = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_INC = 3'b110;
    localparam logic [2:0] OP_DEC = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // The ALU only drives a meaningful cout for arithmetic ops.
    function automatic logic op_has_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_res_reg.sv
// Result holding register: captures the final ALU output and presents it
// over valid/ready until the consumer takes it.
module alu_res_reg
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [2:0]    op,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_cout,
    input  logic          alu_zero,
    input  logic          res_ready,
    output logic          res_valid,
    output logic [DW-1:0] res_y,
    output logic          res_cout,
    output logic          res_zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_cout  <= 1'b0;
            res_zero  <= 1'b0;
        end else if (load) begin
            res_valid <= 1'b1;
            res_y     <= alu_y;
            res_cout  <= op_has_carry(op) & alu_cout;
            res_zero  <= alu_zero;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// ALU command sequencer: cmd handshake -> registered ALU drive -> result
// handshake. ALU_CMD_SEQ_ACC_EN adds accumulator chaining and repeat count.
module alu_cmd_seq
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic          cmd_use_acc,
    input  logic          cmd_clr,
    input  logic [1:0]    cmd_rpt,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [2:0]    alu_sel,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_cout,
    input  logic          alu_zero,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_y,
    output logic          res_cout,
    output logic          res_zero
);

    state_t        state;
    state_t        state_nxt;
    logic          accept;
    logic          last;
    logic          load_res;
    logic [DW-1:0] a_nxt;

`ifdef ALU_CMD_SEQ_ACC_EN
    logic [DW-1:0] acc;
    logic [1:0]    cnt;

    assign last  = (cnt == 2'd0);
    // A cleared accumulator must also feed zero on this same command.
    assign a_nxt = cmd_use_acc ? (cmd_clr ? '0 : acc) : cmd_a;
`else
    logic unused_cfg;

    assign unused_cfg = ^{cmd_use_acc, cmd_clr, cmd_rpt};
    assign last       = 1'b1;
    assign a_nxt      = cmd_a;
`endif

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign load_res  = (state == EXEC) && last;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)    state_nxt = EXEC;
            EXEC:    if (last)      state_nxt = RESP;
            RESP:    if (res_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= '0;
`ifdef ALU_CMD_SEQ_ACC_EN
            acc     <= '0;
            cnt     <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                alu_sel <= cmd_op;
                alu_b   <= cmd_b;
                alu_a   <= a_nxt;
`ifdef ALU_CMD_SEQ_ACC_EN
                cnt     <= cmd_rpt;
                if (cmd_clr) acc <= '0;
`endif
            end
`ifdef ALU_CMD_SEQ_ACC_EN
            else if (state == EXEC) begin
                acc <= alu_y;
                // Feed the result back for the next iteration.
                if (!last) begin
                    alu_a <= alu_y;
                    cnt   <= cnt - 2'd1;
                end
            end
`endif
        end
    end

    alu_res_reg u_res (
        .clk       (clk),
        .rst       (rst),
        .load      (load_res),
        .op        (alu_sel),
        .alu_y     (alu_y),
        .alu_cout  (alu_cout),
        .alu_zero  (alu_zero),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_y     (res_y),
        .res_cout  (res_cout),
        .res_zero  (res_zero)
    );

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Bench for alu_cmd_seq: behavioural ALU, table vectors, corner sequences
// and random commands against a command-level reference model.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic       cmd_use_acc;
    logic       cmd_clr;
    logic [1:0] cmd_rpt;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_y;
    logic       alu_cout;
    logic       alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_y;
    logic       res_cout;
    logic       res_zero;

    int checks = 0;
    int errors = 0;

`ifdef ALU_CMD_SEQ_ACC_EN
    logic [3:0] acc_m = 4'd0;
`endif

    always #5 clk = ~clk;

    alu_cmd_seq dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .cmd_clr     (cmd_clr),
        .cmd_rpt     (cmd_rpt),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_y       (alu_y),
        .alu_cout    (alu_cout),
        .alu_zero    (alu_zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_y       (res_y),
        .res_cout    (res_cout),
        .res_zero    (res_zero)
    );

    // Returns {cout, y}; cout is 0 for logic ops (the expected res_cout).
    function automatic logic [4:0] ref_op(input logic [2:0] op,
                                          input logic [3:0] a,
                                          input logic [3:0] b);
        int ai = int'(a);
        int bi = int'(b);
        int r = 0;
        logic c = 1'b0;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 15); end
            3'd1: begin r = ai - bi; c = (ai < bi); end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: r = 15 - ai;
            3'd6: begin r = ai + 1; c = (ai == 15); end
            default: begin r = ai - 1; c = (ai == 0); end
        endcase
        return {c, 4'(r & 15)};
    endfunction

    // External ALU; drives junk cout=1 on logic ops so masking is visible.
    always_comb begin
        logic [4:0] r;
        r = ref_op(alu_sel, alu_a, alu_b);
        alu_y    = r[3:0];
        alu_cout = (alu_sel inside {3'd2, 3'd3, 3'd4, 3'd5}) ? 1'b1 : r[4];
        alu_zero = (r[3:0] == 4'd0);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic model_cmd(input logic [2:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic ua,
                             input logic clr, input logic [1:0] rpt,
                             output logic [3:0] y, output logic c,
                             output logic z, output logic [3:0] a0,
                             output int lat);
        logic [4:0] r;
        int n;
`ifdef ALU_CMD_SEQ_ACC_EN
        if (clr) acc_m = 4'd0;
        a0 = ua ? acc_m : a;
        n = int'(rpt) + 1;
`else
        a0 = a;
        n = 1 + 0 * int'({ua, clr, rpt});
`endif
        y = a0;
        r = '0;
        for (int i = 0; i < n; i++) begin
            r = ref_op(op, y, b);
            y = r[3:0];
        end
        c = r[4];
        z = (y == 4'd0);
        lat = n + 1;
`ifdef ALU_CMD_SEQ_ACC_EN
        acc_m = y;
`endif
    endtask

    // Entered just after a negedge with the DUT idle; returns likewise.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic ua,
                           input logic clr, input logic [1:0] rpt,
                           input int hold, input logic [3:0] ey,
                           input logic ec, input logic ez,
                           input logic [3:0] ea0, input int elat);
        int cyc;
        logic [31:0] rnd;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_use_acc = ua;
        cmd_clr = clr;
        cmd_rpt = rpt;
        res_ready = 1'b0;
        #1 check("cmd_ready_idle", 32'(cmd_ready), 1);
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("alu_a", 32'(alu_a), 32'(ea0));
                check("alu_b", 32'(alu_b), 32'(b));
                check("alu_sel", 32'(alu_sel), 32'(op));
            end
            if (!res_valid) begin
                rnd = $urandom;
                {cmd_op, cmd_a, cmd_b, cmd_use_acc, cmd_clr, cmd_rpt} =
                    rnd[14:0];
                res_ready = rnd[15];
            end
        end while (!res_valid && cyc < 10);
        check("latency", 32'(cyc), 32'(elat));
        res_ready = 1'b0;
        for (int h = 0; h <= hold; h++) begin
            if (h > 0) @(negedge clk);
            check("res_valid", 32'(res_valid), 1);
            check("res_y", 32'(res_y), 32'(ey));
            check("res_cout", 32'(res_cout), 32'(ec));
            check("res_zero", 32'(res_zero), 32'(ez));
            check("cmd_ready_resp", 32'(cmd_ready), 0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        check("res_valid_drop", 32'(res_valid), 0);
        check("cmd_ready_back", 32'(cmd_ready), 1);
    endtask

    task automatic model_run(input logic [2:0] op, input logic [3:0] a,
                             input logic [3:0] b, input logic ua,
                             input logic clr, input logic [1:0] rpt,
                             input int hold);
        logic [3:0] y;
        logic [3:0] a0;
        logic c;
        logic z;
        int lat;
        model_cmd(op, a, b, ua, clr, rpt, y, c, z, a0, lat);
        run_cmd(op, a, b, ua, clr, rpt, hold, y, c, z, a0, lat);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] y;
        logic       c;
        logic       z;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{3'd0, 4'h9, 4'h8, 4'h1, 1'b1, 1'b0};
        tbl[1] = '{3'd1, 4'h2, 4'h3, 4'hF, 1'b1, 1'b0};
        tbl[2] = '{3'd2, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1};
        tbl[3] = '{3'd3, 4'h5, 4'hA, 4'hF, 1'b0, 1'b0};
        tbl[4] = '{3'd4, 4'h6, 4'h6, 4'h0, 1'b0, 1'b1};
        tbl[5] = '{3'd5, 4'hF, 4'h3, 4'h0, 1'b0, 1'b1};
        tbl[6] = '{3'd6, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1};
        tbl[7] = '{3'd7, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0};
        tbl[8] = '{3'd1, 4'h7, 4'h7, 4'h0, 1'b0, 1'b1};
        tbl[9] = '{3'd0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b1};

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0;
        cmd_a = '0;
        cmd_b = '0;
        cmd_use_acc = 1'b0;
        cmd_clr = 1'b0;
        cmd_rpt = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_y", 32'(res_y), 0);
        check("rst_res_cout", 32'(res_cout), 0);
        check("rst_res_zero", 32'(res_zero), 0);
        check("rst_alu_a", 32'(alu_a), 0);
        check("rst_alu_b", 32'(alu_b), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        rst = 1'b0;
        #1 check("release_cmd_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 10; i++) begin
            logic [3:0] my;
            logic [3:0] a0;
            logic mc;
            logic mz;
            int lat;
            model_cmd(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 2'd0,
                      my, mc, mz, a0, lat);
            run_cmd(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 2'd0,
                    i % 3, tbl[i].y, tbl[i].c, tbl[i].z, a0, 2);
        end

        // Accumulator preload to E, then repeated inc wrapping F,0,1.
        model_run(3'd0, 4'hE, 4'h0, 1'b0, 1'b0, 2'd0, 0);
        model_run(3'd6, 4'hE, 4'h5, 1'b1, 1'b0, 2'd2, 1);
        model_run(3'd0, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 0);
        model_run(3'd0, 4'h3, 4'h2, 1'b1, 1'b1, 2'd1, 0);

        // Backpressure: five stalled cycles with cmd_valid held high.
        model_run(3'd1, 4'h4, 4'h9, 1'b0, 1'b0, 2'd0, 5);
        model_run(3'd4, 4'hA, 4'h3, 1'b0, 1'b0, 2'd0, 0);

        // Reset during EXEC of a long repeat command.
        cmd_valid = 1'b1;
        cmd_op = 3'd6;
        cmd_a = 4'h2;
        cmd_b = 4'h0;
        cmd_use_acc = 1'b0;
        cmd_clr = 1'b0;
        cmd_rpt = 2'd3;
        @(posedge clk);
        @(negedge clk);
        check("midop_exec_valid", 32'(res_valid), 0);
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midop_rst_ready", 32'(cmd_ready), 0);
        check("midop_rst_valid", 32'(res_valid), 0);
        check("midop_rst_alu_a", 32'(alu_a), 0);
        rst = 1'b0;
`ifdef ALU_CMD_SEQ_ACC_EN
        acc_m = 4'd0;
`endif
        repeat (5) begin
            @(negedge clk);
            check("midop_no_res", 32'(res_valid), 0);
        end
        model_run(3'd0, 4'h5, 4'h0, 1'b1, 1'b0, 2'd0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] r;
            r = $urandom;
            model_run(r[2:0], r[6:3], r[10:7], r[11], r[12], r[14:13],
                      int'(r[16:15]) % 3);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
